// File: rtl/conv2_mac_seq_if.sv
// conv2_mac_seq_if: start/result handshake and layer-buffer read port of the conv2 serial MAC
interface conv2_mac_seq_if #(
    parameter int W_W    = 9,
    parameter int X_W    = 22,
    parameter int OUT_W  = 30,
    parameter int ADDR_W = 10
);
    logic                     start;
    logic signed [W_W-1:0]    bias;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [W_W-1:0]    w_data;
    logic signed [X_W-1:0]    x_data;
    logic                     busy;
    logic                     done;
    logic signed [OUT_W-1:0]  result;
    logic                     sat;
    modport master (output start, bias, w_data, x_data, input rd_en, rd_addr, busy, done, result, sat);
    modport slave  (input start, bias, w_data, x_data, output rd_en, rd_addr, busy, done, result, sat);
endinterface

// File: rtl/conv2_mac_seq.sv
// conv2_mac_seq: sequencer and single-multiplier MAC producing one saturated conv2 output
module conv2_mac_seq #(
    parameter int N_TAP  = 800,
    parameter int W_W    = 9,
    parameter int X_W    = 22,
    parameter int OUT_W  = 30,
    parameter int ACC_W  = 42,
    parameter int ADDR_W = 10
) (
    input logic clk,
    input logic rst_n,
    conv2_mac_seq_if.slave m
);
    localparam int PW = W_W + X_W;
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, BIAS, DONE} state_t;
    state_t st, nxt;
    logic [ADDR_W-1:0] cnt;
    logic signed [W_W-1:0] bias_r;
    logic signed [PW-1:0] prod_r;
    logic signed [ACC_W-1:0] acc, s;
    logic signed [OUT_W-1:0] res_r;
    logic rv, pv, dr, last, sat_r;
    assign last = cnt == ADDR_W'(N_TAP - 1);
    assign s = acc + ACC_W'(bias_r);
    assign m.rd_en = st == FETCH;
    assign m.rd_addr = cnt;
    assign m.busy = st != IDLE;
    assign m.done = st == DONE;
    assign m.result = res_r;
    assign m.sat = sat_r;
    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = m.start ? FETCH : IDLE;
            FETCH:   nxt = last ? DRAIN : FETCH;
            DRAIN:   nxt = dr ? BIAS : DRAIN;
            BIAS:    nxt = DONE;
            default: nxt = IDLE;
        endcase
    end
    // rv marks read data arriving, pv marks a product waiting to be accumulated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= IDLE;
            cnt    <= '0;
            bias_r <= '0;
            prod_r <= '0;
            acc    <= '0;
            res_r  <= '0;
            sat_r  <= 1'b0;
            rv     <= 1'b0;
            pv     <= 1'b0;
            dr     <= 1'b0;
        end else begin
            st <= nxt;
            rv <= st == FETCH;
            pv <= rv;
            dr <= st == DRAIN;
            if (rv) prod_r <= PW'(m.w_data) * PW'(m.x_data);
            if (st == IDLE && m.start) begin
                bias_r <= m.bias;
                acc    <= '0;
                cnt    <= '0;
            end else if (pv) acc <= acc + ACC_W'(prod_r);
            if (st == FETCH && !last) cnt <= cnt + ADDR_W'(1);
            if (st == BIAS) begin
                sat_r <= s > MAXV || s < MINV;
                res_r <= s > MAXV ? MAXV[OUT_W-1:0] : s < MINV ? MINV[OUT_W-1:0] : s[OUT_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_conv2_mac_seq.sv
// tb_conv2_mac_seq: directed and seeded-random checks of the conv2 serial MAC
module tb_conv2_mac_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    int w_mem [800];
    int x_mem [800];
    int unsigned seed = 32'd20240611;
    always #5 clk = ~clk;
    conv2_mac_seq_if m();
    conv2_mac_seq dut (.clk(clk), .rst_n(rst_n), .m(m.slave));
    // layer buffer: synchronous read, data one cycle after rd_en
    always @(posedge clk) if (m.rd_en) begin
        m.w_data <= 9'(w_mem[m.rd_addr]);
        m.x_data <= 22'(x_mem[m.rd_addr]);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int w, input int x);
        for (int i = 0; i < 800; i++) begin
            w_mem[i] = w;
            x_mem[i] = x;
        end
    endtask

    task automatic rnd(input int span, output int v);
        seed = seed * 32'd1103515245 + 32'd12345;
        v = int'((seed >> 8) % span);
    endtask

    task automatic model(input int b, output logic signed [29:0] r, output logic s);
        longint sum = longint'(b);
        longint c;
        for (int i = 0; i < 800; i++) sum += longint'(w_mem[i]) * longint'(x_mem[i]);
        s = sum > 536870911 || sum < -536870912;
        c = sum > 536870911 ? 536870911 : sum < -536870912 ? -536870912 : sum;
        r = 30'(c);
    endtask

    task automatic run_op(input int b, input bit pulse, output int lat, output int nrd, output int aerr, output int berr);
        m.bias = 9'(b);
        m.start = 1'b1;
        cyc();
        m.start = 1'b0;
        lat = 1;
        nrd = 0;
        aerr = 0;
        berr = 0;
        while (!m.done && lat < 2000) begin
            if (m.rd_en) begin
                if (m.rd_addr !== 10'(nrd)) aerr++;
                nrd++;
            end
            if (m.busy !== 1'b1) berr++;
            m.start = pulse && lat == 10;
            cyc();
            lat++;
        end
        m.start = 1'b0;
        if (m.busy !== 1'b1) berr++;
    endtask

    task automatic test_reset();
        m.start = 1'b0;
        m.bias = '0;
        rst_n = 1'b0;
        cyc();
        cyc();
        n_cmp++; if ({m.rd_en, m.busy, m.done, m.sat} !== 4'b0) begin n_err++; $display("FAIL reset_flags got=%b want=0000", {m.rd_en, m.busy, m.done, m.sat}); end
        n_cmp++; if (m.result !== 0) begin n_err++; $display("FAIL reset_result got=%0d want=0", m.result); end
        n_cmp++; if (m.rd_addr !== 10'd0) begin n_err++; $display("FAIL reset_addr got=%0d want=0", m.rd_addr); end
        rst_n = 1'b1;
        cyc();
        n_cmp++; if (m.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b want=0", m.busy); end
    endtask

    task automatic test_ones();
        int lat, nrd, aerr, berr;
        fill(1, 1);
        run_op(0, 1'b0, lat, nrd, aerr, berr);
        n_cmp++; if (lat !== 804) begin n_err++; $display("FAIL ones_latency got=%0d want=804", lat); end
        n_cmp++; if (m.result !== 800) begin n_err++; $display("FAIL ones_result got=%0d want=800", m.result); end
        n_cmp++; if (m.sat !== 1'b0) begin n_err++; $display("FAIL ones_sat got=%b want=0", m.sat); end
        cyc();
        n_cmp++; if ({m.done, m.busy} !== 2'b00) begin n_err++; $display("FAIL ones_after_done got=%b want=00", {m.done, m.busy}); end
        n_cmp++; if (m.result !== 800) begin n_err++; $display("FAIL ones_result_held got=%0d want=800", m.result); end
    endtask

    task automatic test_negative();
        int lat, nrd, aerr, berr;
        fill(-1, 3);
        run_op(5, 1'b0, lat, nrd, aerr, berr);
        n_cmp++; if (m.result !== -2395) begin n_err++; $display("FAIL neg_result got=%0d want=-2395", m.result); end
        n_cmp++; if (m.sat !== 1'b0) begin n_err++; $display("FAIL neg_sat got=%b want=0", m.sat); end
        n_cmp++; if (nrd !== 800) begin n_err++; $display("FAIL neg_rd_count got=%0d want=800", nrd); end
        n_cmp++; if (aerr !== 0) begin n_err++; $display("FAIL neg_addr_seq got=%0d want=0 gaps", aerr); end
        n_cmp++; if (berr !== 0) begin n_err++; $display("FAIL neg_busy got=%0d want=0 low cycles", berr); end
        cyc();
    endtask

    task automatic test_saturate();
        int lat, nrd, aerr, berr;
        fill(255, 2097151);
        run_op(0, 1'b0, lat, nrd, aerr, berr);
        n_cmp++; if ({m.sat, m.result} !== {1'b1, 30'sd536870911}) begin n_err++; $display("FAIL sat_pos got=%0d/%b want=536870911/1", m.result, m.sat); end
        cyc();
        fill(-256, 2097151);
        run_op(0, 1'b0, lat, nrd, aerr, berr);
        n_cmp++; if ({m.sat, m.result} !== {1'b1, 30'h20000000}) begin n_err++; $display("FAIL sat_neg got=%0d/%b want=-536870912/1", m.result, m.sat); end
        cyc();
        fill(0, 0);
        w_mem[0] = 255; x_mem[0] = 2097151;
        w_mem[1] = 1;   x_mem[1] = 2097151;
        run_op(255, 1'b0, lat, nrd, aerr, berr);
        n_cmp++; if ({m.sat, m.result} !== {1'b0, 30'sd536870911}) begin n_err++; $display("FAIL edge_max got=%0d/%b want=536870911/0", m.result, m.sat); end
        cyc();
        w_mem[2] = 1; x_mem[2] = 1;
        run_op(255, 1'b0, lat, nrd, aerr, berr);
        n_cmp++; if ({m.sat, m.result} !== {1'b1, 30'sd536870911}) begin n_err++; $display("FAIL edge_max_plus1 got=%0d/%b want=536870911/1", m.result, m.sat); end
        cyc();
        fill(0, 0);
        w_mem[0] = -256; x_mem[0] = 2097151;
        run_op(-256, 1'b0, lat, nrd, aerr, berr);
        n_cmp++; if ({m.sat, m.result} !== {1'b0, 30'h20000000}) begin n_err++; $display("FAIL edge_min got=%0d/%b want=-536870912/0", m.result, m.sat); end
        cyc();
        w_mem[1] = -1; x_mem[1] = 1;
        run_op(-256, 1'b0, lat, nrd, aerr, berr);
        n_cmp++; if ({m.sat, m.result} !== {1'b1, 30'h20000000}) begin n_err++; $display("FAIL edge_min_minus1 got=%0d/%b want=-536870912/1", m.result, m.sat); end
        cyc();
    endtask

    task automatic test_back_to_back();
        int lat, nrd, aerr, berr;
        fill(1, 1);
        run_op(0, 1'b1, lat, nrd, aerr, berr);
        n_cmp++; if (lat !== 804) begin n_err++; $display("FAIL b2b_first_latency got=%0d want=804", lat); end
        n_cmp++; if (m.result !== 800) begin n_err++; $display("FAIL b2b_first_result got=%0d want=800", m.result); end
        m.start = 1'b1;
        cyc();
        n_cmp++; if ({m.done, m.busy} !== 2'b00) begin n_err++; $display("FAIL b2b_start_in_done got=%b want=00", {m.done, m.busy}); end
        run_op(0, 1'b0, lat, nrd, aerr, berr);
        n_cmp++; if (lat !== 804) begin n_err++; $display("FAIL b2b_second_latency got=%0d want=804", lat); end
        n_cmp++; if (m.result !== 800) begin n_err++; $display("FAIL b2b_second_result got=%0d want=800", m.result); end
        cyc();
    endtask

    task automatic test_reset_mid();
        int lat, nrd, aerr, berr, n;
        fill(-1, 3);
        m.bias = 9'sd5;
        m.start = 1'b1;
        cyc();
        m.start = 1'b0;
        for (n = 0; n < 1000 && !(m.rd_en && m.rd_addr == 10'd400); n++) cyc();
        n_cmp++; if (n !== 400) begin n_err++; $display("FAIL mid_reach_400 got=%0d want=400 cycles", n); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({m.rd_en, m.busy, m.done} !== 3'b000) begin n_err++; $display("FAIL mid_reset_flags got=%b want=000", {m.rd_en, m.busy, m.done}); end
        n_cmp++; if (m.result !== 0) begin n_err++; $display("FAIL mid_reset_result got=%0d want=0", m.result); end
        cyc();
        rst_n = 1'b1;
        cyc();
        run_op(5, 1'b0, lat, nrd, aerr, berr);
        n_cmp++; if (lat !== 804) begin n_err++; $display("FAIL mid_restart_latency got=%0d want=804", lat); end
        n_cmp++; if (m.result !== -2395) begin n_err++; $display("FAIL mid_restart_result got=%0d want=-2395", m.result); end
        cyc();
    endtask

    task automatic test_random();
        int lat, nrd, aerr, berr, b, v;
        logic signed [29:0] er;
        logic es;
        for (int r = 0; r < 50; r++) begin
            for (int i = 0; i < 800; i++) begin
                rnd(512, v);
                w_mem[i] = v - 256;
                if (r % 2 == 1) begin
                    rnd(32768, v);
                    x_mem[i] = v - 16384;
                end else begin
                    rnd(4194304, v);
                    x_mem[i] = v - 2097152;
                end
            end
            rnd(512, v);
            b = v - 256;
            model(b, er, es);
            run_op(b, 1'b0, lat, nrd, aerr, berr);
            n_cmp++; if (m.result !== er) begin n_err++; $display("FAIL rand%0d_result got=%0d want=%0d", r, m.result, er); end
            n_cmp++; if (m.sat !== es) begin n_err++; $display("FAIL rand%0d_sat got=%b want=%b", r, m.sat, es); end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_negative();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
